// File: rtl/bp_common_cfg_link_pkg.sv
// Shared definitions for the per-tile config register responder:
// config window geometry, register offsets and responder states.
package bp_common_cfg_link_pkg;

  localparam int cfg_window_bits_lp = 16;
  localparam logic [39:0] cfg_base_addr_gp = 40'h00_0020_0000;

  typedef enum logic [15:0] {
    e_cfg_freeze      = 16'h0000,
    e_cfg_core_id     = 16'h0008,
    e_cfg_icache_mode = 16'h0010,
    e_cfg_dcache_mode = 16'h0018,
    e_cfg_cce_mode    = 16'h0020,
    e_cfg_scratch     = 16'h0028,
    e_cfg_err_count   = 16'h0030
  } bp_cfg_reg_e;

  typedef enum logic {
    e_ready,
    e_resp
  } bp_cfg_state_e;

endpackage

// File: rtl/bsg_one_fifo.sv
// Single-entry buffer holding one response; enqueue and dequeue may
// happen in the same cycle so the responder keeps full throughput.
module bsg_one_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic               full_r;
  logic [width_p-1:0] data_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_r <= 1'b0;
      data_r <= '0;
    end else if (v_i) begin
      full_r <= 1'b1;
      data_r <= data_i;
    end else if (yumi_i) begin
      full_r <= 1'b0;
    end
  end

  assign v_o    = full_r;
  assign data_o = data_r;

endmodule

// File: rtl/bp_cfg_reg_responder.sv
// Uncached IO responder for a tile's config window: decodes commands,
// owns the config registers and returns one in-order response each.
module bp_cfg_reg_responder
  import bp_common_cfg_link_pkg::*;
#(
  parameter int paddr_width_p   = 40,
  parameter int dword_width_p   = 64,
  parameter int core_id_width_p = 4,
  parameter int payload_width_p = 8,
  parameter logic [paddr_width_p-1:0] cfg_base_addr_p = cfg_base_addr_gp
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       cmd_v_i,
  output logic                       cmd_yumi_o,
  input  logic                       cmd_wr_i,
  input  logic [paddr_width_p-1:0]   cmd_addr_i,
  input  logic [1:0]                 cmd_size_i,
  input  logic [dword_width_p-1:0]   cmd_data_i,
  input  logic [payload_width_p-1:0] cmd_payload_i,
  output logic                       resp_v_o,
  input  logic                       resp_ready_i,
  output logic                       resp_wr_o,
  output logic [paddr_width_p-1:0]   resp_addr_o,
  output logic [1:0]                 resp_size_o,
  output logic [dword_width_p-1:0]   resp_data_o,
  output logic [payload_width_p-1:0] resp_payload_o,
  output logic                       freeze_o,
  output logic [core_id_width_p-1:0] core_id_o,
  output logic [1:0]                 icache_mode_o,
  output logic [1:0]                 dcache_mode_o,
  output logic                       cce_mode_o,
  output logic [7:0]                 err_count_o
);

  localparam int resp_width_lp =
    1 + paddr_width_p + 2 + dword_width_p + payload_width_p;

  bp_cfg_state_e state_r, state_n;

  logic                       freeze_r;
  logic [core_id_width_p-1:0] core_id_r;
  logic [1:0]                 icache_r;
  logic [1:0]                 dcache_r;
  logic                       cce_r;
  logic [dword_width_p-1:0]   scratch_r;
  logic [7:0]                 err_r;

  logic                          hit;
  logic                          mapped;
  logic [cfg_window_bits_lp-1:0] off;
  logic [dword_width_p-1:0]      mask;
  logic [dword_width_p-1:0]      wdata;
  logic [dword_width_p-1:0]      rd_val;
  logic [dword_width_p-1:0]      rd_data;
  logic [resp_width_lp-1:0]      resp_bits;

  assign hit = cmd_addr_i[paddr_width_p-1:cfg_window_bits_lp]
            == cfg_base_addr_p[paddr_width_p-1:cfg_window_bits_lp];
  assign off = {cmd_addr_i[cfg_window_bits_lp-1:3], 3'b000};

  // 8B access shifts every bit out, leaving an all-ones mask
  assign mask  = ~({dword_width_p{1'b1}} << (32'd8 << cmd_size_i));
  assign wdata = cmd_data_i & mask;

  always_comb begin
    mapped = 1'b0;
    rd_val = '0;
    if (hit) begin
      case (off)
        e_cfg_freeze: begin
          mapped = 1'b1;
          rd_val = dword_width_p'(freeze_r);
        end
        e_cfg_core_id: begin
          mapped = 1'b1;
          rd_val = dword_width_p'(core_id_r);
        end
        e_cfg_icache_mode: begin
          mapped = 1'b1;
          rd_val = dword_width_p'(icache_r);
        end
        e_cfg_dcache_mode: begin
          mapped = 1'b1;
          rd_val = dword_width_p'(dcache_r);
        end
        e_cfg_cce_mode: begin
          mapped = 1'b1;
          rd_val = dword_width_p'(cce_r);
        end
        e_cfg_scratch: begin
          mapped = 1'b1;
          rd_val = scratch_r;
        end
        e_cfg_err_count: begin
          mapped = 1'b1;
          rd_val = dword_width_p'(err_r);
        end
        default: ;
      endcase
    end
  end

  assign rd_data = cmd_wr_i ? '0 : (rd_val & mask);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n    = state_r;
    cmd_yumi_o = 1'b0;
    unique case (state_r)
      e_ready: begin
        cmd_yumi_o = cmd_v_i;
        if (cmd_v_i) state_n = e_resp;
      end
      e_resp: begin
        if (resp_ready_i) begin
          cmd_yumi_o = cmd_v_i;
          state_n    = cmd_v_i ? e_resp : e_ready;
        end
      end
      default: state_n = e_ready;
    endcase
    if (reset_i) cmd_yumi_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      freeze_r  <= 1'b1;
      core_id_r <= '0;
      icache_r  <= '0;
      dcache_r  <= '0;
      cce_r     <= 1'b0;
      scratch_r <= '0;
      err_r     <= '0;
    end else if (cmd_yumi_o) begin
      if (cmd_wr_i && hit) begin
        case (off)
          e_cfg_freeze:      freeze_r  <= wdata[0];
          e_cfg_core_id:     core_id_r <= wdata[core_id_width_p-1:0];
          e_cfg_icache_mode: icache_r  <= wdata[1:0];
          e_cfg_dcache_mode: dcache_r  <= wdata[1:0];
          e_cfg_cce_mode:    cce_r     <= wdata[0];
          e_cfg_scratch:     scratch_r <= wdata;
          default: ;
        endcase
      end
      if (!mapped && err_r != 8'hFF) err_r <= err_r + 8'd1;
    end
  end

  bsg_one_fifo #(
    .width_p(resp_width_lp)
  ) resp_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (cmd_yumi_o),
    .data_i ({cmd_wr_i, cmd_addr_i, cmd_size_i, rd_data, cmd_payload_i}),
    .v_o    (resp_v_o),
    .data_o (resp_bits),
    .yumi_i (resp_v_o & resp_ready_i)
  );

  assign {resp_wr_o, resp_addr_o, resp_size_o,
          resp_data_o, resp_payload_o} = resp_bits;

  assign freeze_o      = freeze_r;
  assign core_id_o     = core_id_r;
  assign icache_mode_o = icache_r;
  assign dcache_mode_o = dcache_r;
  assign cce_mode_o    = cce_r;
  assign err_count_o   = err_r;

endmodule

// File: tb/tb_bp_cfg_reg_responder.sv
// Directed bench for bp_cfg_reg_responder: register map, size masking,
// unmapped accesses, back-pressure, throughput and reset behaviour.
module tb_bp_cfg_reg_responder;

  localparam logic [39:0] base = 40'h00_0020_0000;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        cmd_v_i;
  logic        cmd_yumi_o;
  logic        cmd_wr_i;
  logic [39:0] cmd_addr_i;
  logic [1:0]  cmd_size_i;
  logic [63:0] cmd_data_i;
  logic [7:0]  cmd_payload_i;
  logic        resp_v_o;
  logic        resp_ready_i;
  logic        resp_wr_o;
  logic [39:0] resp_addr_o;
  logic [1:0]  resp_size_o;
  logic [63:0] resp_data_o;
  logic [7:0]  resp_payload_o;
  logic        freeze_o;
  logic [3:0]  core_id_o;
  logic [1:0]  icache_mode_o;
  logic [1:0]  dcache_mode_o;
  logic        cce_mode_o;
  logic [7:0]  err_count_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bp_cfg_reg_responder dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .cmd_v_i       (cmd_v_i),
    .cmd_yumi_o    (cmd_yumi_o),
    .cmd_wr_i      (cmd_wr_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_size_i    (cmd_size_i),
    .cmd_data_i    (cmd_data_i),
    .cmd_payload_i (cmd_payload_i),
    .resp_v_o      (resp_v_o),
    .resp_ready_i  (resp_ready_i),
    .resp_wr_o     (resp_wr_o),
    .resp_addr_o   (resp_addr_o),
    .resp_size_o   (resp_size_o),
    .resp_data_o   (resp_data_o),
    .resp_payload_o(resp_payload_o),
    .freeze_o      (freeze_o),
    .core_id_o     (core_id_o),
    .icache_mode_o (icache_mode_o),
    .dcache_mode_o (dcache_mode_o),
    .cce_mode_o    (cce_mode_o),
    .err_count_o   (err_count_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic wr,
                       input logic [39:0] addr, input logic [1:0] size,
                       input logic [63:0] data, input logic [7:0] pl);
    cmd_v_i       = v;
    cmd_wr_i      = wr;
    cmd_addr_i    = addr;
    cmd_size_i    = size;
    cmd_data_i    = data;
    cmd_payload_i = pl;
  endtask

  initial begin
    reset_i      = 1'b1;
    resp_ready_i = 1'b1;
    drive(1'b1, 1'b0, base, 2'd3, 64'h0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rst_yumi", cmd_yumi_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_freeze", freeze_o, 1);
    chk("rst_err", err_count_o, 0);

    // read freeze after reset
    reset_i = 1'b0;
    drive(1'b1, 1'b0, base, 2'd3, 64'h0, 8'hA5);
    #1;
    chk("rd0_yumi", cmd_yumi_o, 1);
    chk("rd0_v_early", resp_v_o, 0);
    @(negedge clk);
    chk("rd0_v", resp_v_o, 1);
    chk("rd0_data", resp_data_o, 64'h1);
    chk("rd0_addr", resp_addr_o, base);
    chk("rd0_pl", resp_payload_o, 8'hA5);
    chk("rd0_wr", resp_wr_o, 0);
    chk("rd0_size", resp_size_o, 2'd3);
    drive(1'b0, 1'b0, base, 2'd3, 64'h0, 8'h00);
    @(negedge clk);
    chk("rd0_drain", resp_v_o, 0);

    // core_id byte write, back-to-back read
    drive(1'b1, 1'b1, base + 40'h8, 2'd0,
          64'hFFFF_FFFF_FFFF_FFF5, 8'h01);
    @(negedge clk);
    chk("cid_out", core_id_o, 4'h5);
    chk("cid_wr_data", resp_data_o, 0);
    chk("cid_wr_echo", resp_wr_o, 1);
    drive(1'b1, 1'b0, base + 40'h8, 2'd3, 64'h0, 8'h02);
    #1;
    chk("cid_b2b_yumi", cmd_yumi_o, 1);
    @(negedge clk);
    chk("cid_rd", resp_data_o, 64'h5);
    chk("cid_rd_pl", resp_payload_o, 8'h02);

    // scratch full write, 2B read with low addr bits set
    drive(1'b1, 1'b1, base + 40'h28, 2'd3,
          64'h1122_3344_5566_7788, 8'h03);
    @(negedge clk);
    drive(1'b1, 1'b0, base + 40'h2E, 2'd1, 64'h0, 8'h04);
    @(negedge clk);
    chk("scr_rd16", resp_data_o, 64'h7788);
    drive(1'b1, 1'b1, base + 40'h18, 2'd0, 64'h6, 8'h05);
    @(negedge clk);
    chk("dc_trunc", dcache_mode_o, 2'd2);
    drive(1'b1, 1'b1, base + 40'h20, 2'd0, 64'h3, 8'h06);
    @(negedge clk);
    chk("cce_trunc", cce_mode_o, 1);

    // unmapped offset and decode miss
    drive(1'b1, 1'b0, base + 40'h40, 2'd3, 64'h0, 8'h07);
    @(negedge clk);
    chk("um_rd_v", resp_v_o, 1);
    chk("um_rd_data", resp_data_o, 0);
    chk("um_err1", err_count_o, 1);
    drive(1'b1, 1'b1, base + 40'h1_0000, 2'd3, 64'hFF, 8'h08);
    @(negedge clk);
    chk("miss_wr", resp_wr_o, 1);
    chk("um_err2", err_count_o, 2);
    drive(1'b1, 1'b1, base + 40'h30, 2'd3, 64'h77, 8'h09);
    @(negedge clk);
    chk("err_ro", err_count_o, 2);
    drive(1'b1, 1'b0, base + 40'h30, 2'd3, 64'h0, 8'h0A);
    @(negedge clk);
    chk("err_rd", resp_data_o, 64'h2);

    drive(1'b1, 1'b0, 40'h0, 2'd3, 64'h0, 8'h0B);
    for (int i = 0; i < 300; i++) @(negedge clk);
    chk("err_sat", err_count_o, 8'hFF);
    drive(1'b1, 1'b0, base + 40'h30, 2'd0, 64'h0, 8'h0C);
    @(negedge clk);
    chk("err_sat_rd", resp_data_o, 64'hFF);
    drive(1'b0, 1'b0, 40'h0, 2'd0, 64'h0, 8'h00);
    @(negedge clk);

    // back-pressure then full throughput
    drive(1'b1, 1'b0, base + 40'h8, 2'd3, 64'h0, 8'h20);
    @(negedge clk);
    resp_ready_i = 1'b0;
    drive(1'b1, 1'b0, base, 2'd3, 64'h0, 8'h21);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_yumi", cmd_yumi_o, 0);
      chk("stall_v", resp_v_o, 1);
      chk("stall_pl", resp_payload_o, 8'h20);
      chk("stall_data", resp_data_o, 64'h5);
      @(negedge clk);
    end
    resp_ready_i = 1'b1;
    #1;
    chk("unstall_yumi", cmd_yumi_o, 1);
    @(negedge clk);
    chk("q0_pl", resp_payload_o, 8'h21);
    chk("q0_data", resp_data_o, 64'h1);
    drive(1'b1, 1'b0, base + 40'h28, 2'd2, 64'h0, 8'h22);
    @(negedge clk);
    chk("q1_pl", resp_payload_o, 8'h22);
    chk("q1_data", resp_data_o, 64'h5566_7788);
    drive(1'b1, 1'b1, base + 40'h10, 2'd0, 64'h3, 8'h23);
    @(negedge clk);
    chk("q2_pl", resp_payload_o, 8'h23);
    chk("q2_icache", icache_mode_o, 2'd3);
    drive(1'b1, 1'b0, base + 40'h10, 2'd3, 64'h0, 8'h24);
    @(negedge clk);
    chk("q3_pl", resp_payload_o, 8'h24);
    chk("q3_data", resp_data_o, 64'h3);
    drive(1'b0, 1'b0, 40'h0, 2'd0, 64'h0, 8'h00);
    @(negedge clk);
    chk("q_empty", resp_v_o, 0);

    // reset with a pending response
    resp_ready_i = 1'b0;
    drive(1'b1, 1'b1, base, 2'd0, 64'h0, 8'h30);
    @(negedge clk);
    chk("pre_rst_freeze", freeze_o, 0);
    chk("pre_rst_v", resp_v_o, 1);
    reset_i = 1'b1;
    drive(1'b1, 1'b0, base, 2'd3, 64'h0, 8'h31);
    resp_ready_i = 1'b1;
    #1;
    chk("in_rst_yumi", cmd_yumi_o, 0);
    @(negedge clk);
    chk("post_rst_v", resp_v_o, 0);
    chk("post_rst_freeze", freeze_o, 1);
    chk("post_rst_cid", core_id_o, 0);
    chk("post_rst_ic", icache_mode_o, 0);
    chk("post_rst_dc", dcache_mode_o, 0);
    chk("post_rst_cce", cce_mode_o, 0);
    chk("post_rst_err", err_count_o, 0);
    chk("post_rst_data", resp_data_o, 0);
    chk("post_rst_addr", resp_addr_o, 0);
    chk("post_rst_pl", resp_payload_o, 0);
    reset_i = 1'b0;
    drive(1'b1, 1'b0, base + 40'h28, 2'd3, 64'h0, 8'h32);
    @(negedge clk);
    chk("post_rst_scr", resp_data_o, 0);
    drive(1'b0, 1'b0, 40'h0, 2'd0, 64'h0, 8'h00);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_cfg_reg_responder.md
Name: bp_cfg_reg_responder

Overview:
- Responder end of the uncached IO command/response protocol that the CCE MMIO config loader drives.
- Accepts read/write commands addressed to a tile's configuration window and holds the architectural config registers: freeze, core_id, cache modes, CCE mode, scratch and an error counter.
- Returns exactly one response per command, in order, and drives the register values to the tile.
- Sits behind the IO link client in each tile, in place of the per-tile config decode.

Parameters:
- paddr_width_p, 40, physical address width
- dword_width_p, 64, data width of cmd/resp
- core_id_width_p, 4, width of core_id register
- payload_width_p, 8, opaque payload echoed in responses (LCE id)
- cfg_base_addr_p, 40'h00_0020_0000, base of 64 KiB config window

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cmd_v_i  in  1  command valid
- cmd_yumi_o  out  1  command consumed this cycle
- cmd_wr_i  in  1  1=uncached write, 0=uncached read
- cmd_addr_i  in  paddr_width_p  byte address
- cmd_size_i  in  2  0=1B,1=2B,2=4B,3=8B
- cmd_data_i  in  dword_width_p  write data
- cmd_payload_i  in  payload_width_p  echoed payload
- resp_v_o  out  1  response valid
- resp_ready_i  in  1  response accepted when resp_v_o&resp_ready_i
- resp_wr_o  out  1  echo of cmd_wr_i
- resp_addr_o  out  paddr_width_p  echo of cmd_addr_i
- resp_size_o  out  2  echo of cmd_size_i
- resp_data_o  out  dword_width_p  read data; 0 for writes
- resp_payload_o  out  payload_width_p  echo of cmd_payload_i
- freeze_o  out  1  core freeze
- core_id_o  out  core_id_width_p
- icache_mode_o  out  2
- dcache_mode_o  out  2
- cce_mode_o  out  1
- err_count_o  out  8  unmapped-access count

Behaviour:
- Decode: hit iff cmd_addr_i[paddr-1:16]==cfg_base_addr_p[paddr-1:16]. Offset = addr[15:3]*8; addr[2:0] ignored.
- Register map: 0x00 freeze (reset 1), 0x08 core_id (reset 0), 0x10 icache_mode (reset 0), 0x18 dcache_mode (reset 0), 0x20 cce_mode (reset 0), 0x28 scratch 64b (reset 0), 0x30 err_count 8b RO (reset 0).
- Any other offset, or a decode miss, is unmapped:
  - write is ignored; read returns 0;
  - err_count increments, saturating at 8'hFF.
- A write to 0x30 is ignored and does not count as an error.
- Write width:
  - mask cmd_data_i to its low 8<<size bits, then truncate to the register width;
  - the register updates at the accept edge and is visible on the outputs the next cycle.
- Read width: register value zero-extended to 64b, then masked to the low 8<<size bits.
- FSM has two states, e_ready and e_resp (one-entry response buffer):
  - e_ready: cmd_yumi_o=cmd_v_i. On accept, capture the response and go to e_resp.
  - e_resp: resp_v_o=1.
    - resp_ready_i=1 and cmd_v_i=1: drain and accept in the same cycle, stay in e_resp (full throughput).
    - resp_ready_i=1 and cmd_v_i=0: go to e_ready.
    - resp_ready_i=0: cmd_yumi_o=0 and all resp_* outputs stay stable.
- Latency: command accepted in cycle N gives resp_v_o in N+1.
- Back-to-back read after write to the same register returns the new value.
- cmd_yumi_o never asserts without cmd_v_i.
- Reset:
  - all registers return to reset values; state goes to e_ready; resp_v_o=0 and cmd_yumi_o=0 during reset;
  - a pending response at reset is dropped;
  - resp_data_o/addr/payload reset to 0.
- The err_count update and a simultaneous read of err_count: the read returns the pre-increment value.

Decomposition:
- bp_common_cfg_link_pkg holds:
  - enum bp_cfg_reg_e with the offsets above;
  - localparam cfg_window_bits_lp=16;
  - the cfg_base_addr default.
- The response buffer is a bsg_one_fifo instance. Decode, size masking and the register file live in the top module. No other sub-module.

Test Plan:
- Reset, then read 0x00 (size 3) -> resp_data_o=1, freeze_o=1, resp echoes addr/payload, resp_v_o one cycle after yumi.
- Write 0x08 data 64'hFFFF_FFFF_FFFF_FFF5 size 0, then read back to back -> core_id_o=4'h5 the cycle after the write; read returns 64'h5.
- Write scratch 64'h1122_3344_5566_7788 size 3, read size 1 -> resp_data_o=64'h7788.
- Read offset 0x40, then write to base+0x1_0000 -> both responses issued, read data 0, err_count_o=2; 300 unmapped accesses -> err_count_o=8'hFF.
- Hold resp_ready_i=0 for 5 cycles with cmd_v_i=1 -> one accept only, resp_* stable; then hold resp_ready_i=1 with 4 queued cmds -> one response per cycle, in order.
- Assert reset_i while in e_resp -> next cycle resp_v_o=0, freeze_o=1, all registers at reset values.
